// File: rtl/nibble_unpacker.sv
// rtl/nibble_unpacker.sv - word-to-nibble unpacker, LS nibble first; optional out_parity under NIBBLE_UNPACK_PARITY_EN
module nibble_unpacker #(
    parameter int NIBBLES = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_data,
    output logic                 out_last,
    output logic                 busy
`ifdef NIBBLE_UNPACK_PARITY_EN
    ,
    output logic                 out_parity
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  hold, hold_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          accept;
    logic          nib_hs;

    assign out_valid = (state == SHIFT);
    assign busy      = out_valid;
    assign out_data  = hold[3:0];
    assign out_last  = out_valid & (idx == LAST_IDX);
    // A new word may enter while empty or while the last nibble is leaving.
    assign in_ready  = reset_n & ~flush & (~out_valid | (out_last & out_ready));
    assign accept    = in_valid & in_ready;
    assign nib_hs    = out_valid & out_ready;

`ifdef NIBBLE_UNPACK_PARITY_EN
    // hold is zero while empty, so parity is naturally 0 then.
    assign out_parity = ^hold[3:0];
`endif

    // Next-state: load beats shift; the last nibble either empties or reloads.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        idx_nxt   = idx;
        if (accept) begin
            state_nxt = SHIFT;
            hold_nxt  = in_data;
            idx_nxt   = '0;
        end else if (nib_hs) begin
            if (out_last) begin
                state_nxt = EMPTY;
                hold_nxt  = '0;
                idx_nxt   = '0;
            end else begin
                hold_nxt  = {4'b0000, hold[W-1:4]};
                idx_nxt   = idx + IW'(1);
            end
        end
    end

    // State register; reset and flush both discard the held word.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            state <= EMPTY;
            hold  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            idx   <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_nibble_unpacker.sv
// tb/tb_nibble_unpacker.sv - randomized scoreboard bench for nibble_unpacker
module tb_nibble_unpacker;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_data;
    logic         out_last;
    logic         busy;
`ifdef NIBBLE_UNPACK_PARITY_EN
    logic         out_parity;
`endif

    nibble_unpacker #(.NIBBLES(NIBBLES)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef NIBBLE_UNPACK_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    bit mon_en  = 1'b0;

    // Nibbles of the word(s) still owed downstream, oldest first.
    logic [3:0] exp_q[$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Monitor: sample mid-cycle, compare against the nibble queue, then apply the coming edge.
    always @(negedge clock) begin
        if (mon_en) begin
            bit e_valid;
            bit e_ready;
            e_valid = (exp_q.size() > 0);
            e_ready = reset_n && !flush && (!e_valid || (exp_q.size() == 1 && out_ready));
            chk("out_valid", {3'b0, out_valid}, {3'b0, e_valid});
            chk("in_ready",  {3'b0, in_ready},  {3'b0, e_ready});
            chk("busy",      {3'b0, busy},      {3'b0, e_valid});
            if (e_valid) begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_last", {3'b0, out_last}, {3'b0, exp_q.size() == 1});
`ifdef NIBBLE_UNPACK_PARITY_EN
                chk("out_parity", {3'b0, out_parity}, {3'b0, ^exp_q[0]});
`endif
            end else begin
                chk("out_data_idle", out_data, 4'h0);
                chk("out_last_idle", {3'b0, out_last}, 4'h0);
`ifdef NIBBLE_UNPACK_PARITY_EN
                chk("out_parity_idle", {3'b0, out_parity}, 4'h0);
`endif
            end
            if (!reset_n || flush) begin
                exp_q.delete();
            end else begin
                if (e_valid && out_ready) void'(exp_q.pop_front());
                if (in_valid && e_ready)
                    for (int i = 0; i < NIBBLES; i++) exp_q.push_back(in_data[4*i +: 4]);
            end
        end
    end

    // One driven cycle: inputs change just after the rising edge.
    task automatic cyc(input bit rn, input bit f, input bit iv, input logic [W-1:0] d, input bit ordy);
        reset_n   = rn;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        cyc(0, 0, 0, 16'h0000, 0);
        // single word
        cyc(1, 0, 1, 16'h1234, 1);
        repeat (5) cyc(1, 0, 0, 16'h0000, 1);
        // back-to-back words
        cyc(1, 0, 1, 16'h1234, 1);
        repeat (4) cyc(1, 0, 1, 16'hABCD, 1);
        repeat (5) cyc(1, 0, 0, 16'h0000, 1);
        // backpressure on nibble 2
        cyc(1, 0, 1, 16'h1234, 1);
        repeat (2) cyc(1, 0, 0, 16'h0000, 1);
        repeat (3) cyc(1, 0, 0, 16'h0000, 0);
        repeat (3) cyc(1, 0, 0, 16'h0000, 1);
        // flush while nibble 1 shown, with a competing offer
        cyc(1, 0, 1, 16'h5678, 1);
        cyc(1, 0, 0, 16'h0000, 1);
        cyc(1, 1, 1, 16'h9ABC, 1);
        cyc(1, 0, 1, 16'h9ABC, 1);
        repeat (5) cyc(1, 0, 0, 16'h0000, 1);
        // reset mid-word
        cyc(1, 0, 1, 16'hABCD, 1);
        cyc(1, 0, 0, 16'h0000, 1);
        repeat (2) cyc(0, 0, 1, 16'hABCD, 1);
        cyc(1, 0, 0, 16'h0000, 1);
        // parity pattern
        cyc(1, 0, 1, 16'h7F30, 1);
        repeat (5) cyc(1, 0, 0, 16'h0000, 1);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(99) != 0), ($urandom_range(39) == 0),
                ($urandom_range(9) < 7), W'($urandom), ($urandom_range(9) < 7));
        end
        // streaming at full rate
        for (int n = 0; n < 200; n++) cyc(1, 0, 1, W'($urandom), 1);
        repeat (6) cyc(1, 0, 0, 16'h0000, 1);
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
